// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision normalizer datapath.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

endpackage

// File: rtl/norm_shift_step.sv
// One combinational normalization step.
// Right mode: divide the significand by two, folding bits 1 and 0 into a sticky bit 0,
// and bump the exponent, saturating to all-ones with a zero mantissa.
// Left mode: double the significand and drop the exponent by one; if the hidden bit
// is still clear once the exponent would reach 1, the result is subnormal
// (exponent 0, mantissa left as it is).
module norm_shift_step #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic              dirRight,
    input  logic [MANT_W+1:0] sigIn,
    input  logic [EXP_W-1:0]  expIn,
    output logic [MANT_W+1:0] sigOut,
    output logic [EXP_W-1:0]  expOut,
    output logic              normalized,
    output logic              overflow,
    output logic              underflow
);
    import fp_pkg::*;

    localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    // Single shift with exponent adjust and saturation/subnormal decision
    always_comb begin
        sigOut     = '0;
        expOut     = '0;
        normalized = 1'b0;
        overflow   = 1'b0;
        underflow  = 1'b0;
        if (dirRight) begin
            sigOut = {1'b0, sigIn[MANT_W+1:2], sigIn[1] | sigIn[0]};
            expOut = expIn + 1'b1;
            if (expOut == EXP_SAT) begin
                sigOut   = '0;
                overflow = 1'b1;
            end
            normalized = sigOut[MANT_W];
        end else begin
            sigOut     = {sigIn[MANT_W:0], 1'b0};
            expOut     = expIn - 1'b1;
            normalized = sigOut[MANT_W];
            if (!normalized && expOut == EXP_ONE) begin
                expOut    = '0;
                underflow = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Post-normalizer between the adder/multiplier stage and the rounder.
// Brings the hidden bit to position MANT_W (one right shift on carry-out, or one
// left shift per cycle) and presents fraction, exponent and flags through a
// valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for an operand, inReady high
// SHIFT | left-shifting one bit per cycle until normalized or subnormal
// DONE  | result valid, held until outReady
module fp_normalizer #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inSign,
    input  logic [EXP_W-1:0]  inExponent,
    input  logic [MANT_W+1:0] inSignificand,
    output logic              outValid,
    input  logic              outReady,
    output logic              outSign,
    output logic [EXP_W-1:0]  outExponent,
    output logic [MANT_W-1:0] outMantissa,
    output logic              outZero,
    output logic              outOverflow,
    output logic              outUnderflow
);
    import fp_pkg::*;

    localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    norm_state_t state, stateNext;

    logic [MANT_W+1:0] sigReg;
    logic [EXP_W-1:0]  expReg;
    logic              signReg;
    logic              zeroReg;
    logic              ovfReg;
    logic              ufReg;

    logic accept;
    logic isSpecial, isZero, hasCarry, hasHidden, tooSmall, needShift;

    logic              stepRight;
    logic [MANT_W+1:0] stepSigIn, stepSigOut;
    logic [EXP_W-1:0]  stepExpIn, stepExpOut;
    logic              stepNorm, stepOvf, stepUf;

    assign accept = inValid && inReady;

    // Classify the incoming operand; priority follows the order of the checks
    always_comb begin
        isSpecial = (inExponent == EXP_SAT);
        isZero    = (inSignificand == '0);
        hasCarry  = inSignificand[MANT_W+1];
        hasHidden = inSignificand[MANT_W];
        tooSmall  = (inExponent <= EXP_ONE);
        needShift = !isSpecial && !isZero && !hasCarry && !hasHidden && !tooSmall;
    end

    // The step unit does the carry right-shift in IDLE and the left shifts in SHIFT
    assign stepRight = (state == IDLE);
    assign stepSigIn = stepRight ? inSignificand : sigReg;
    assign stepExpIn = stepRight ? inExponent : expReg;

    norm_shift_step #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) uStep (
        .dirRight   (stepRight),
        .sigIn      (stepSigIn),
        .expIn      (stepExpIn),
        .sigOut     (stepSigOut),
        .expOut     (stepExpOut),
        .normalized (stepNorm),
        .overflow   (stepOvf),
        .underflow  (stepUf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) stateNext = needShift ? SHIFT : DONE;
            end
            SHIFT: begin
                if (stepNorm || stepUf) stateNext = DONE;
            end
            DONE: begin
                if (outReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs; inReady is gated by reset so it stays low while held in reset
    always_comb begin
        inReady  = (state == IDLE) && rst_n;
        outValid = (state == DONE);
    end

    // Working/result registers: loaded on capture, advanced in SHIFT, frozen in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sigReg  <= '0;
            expReg  <= '0;
            signReg <= 1'b0;
            zeroReg <= 1'b0;
            ovfReg  <= 1'b0;
            ufReg   <= 1'b0;
        end else if (state == IDLE && accept) begin
            signReg <= inSign;
            zeroReg <= 1'b0;
            ovfReg  <= 1'b0;
            ufReg   <= 1'b0;
            if (isSpecial) begin
                sigReg <= inSignificand;
                expReg <= inExponent;
            end else if (isZero) begin
                sigReg  <= '0;
                expReg  <= '0;
                zeroReg <= 1'b1;
            end else if (hasCarry) begin
                sigReg <= stepSigOut;
                expReg <= stepExpOut;
                ovfReg <= stepOvf;
            end else if (hasHidden) begin
                sigReg <= inSignificand;
                expReg <= inExponent;
            end else if (tooSmall) begin
                sigReg <= inSignificand;
                expReg <= '0;
                ufReg  <= 1'b1;
            end else begin
                sigReg <= inSignificand;
                expReg <= inExponent;
            end
        end else if (state == SHIFT) begin
            sigReg <= stepSigOut;
            expReg <= stepExpOut;
            ufReg  <= stepUf;
        end
    end

    assign outSign      = signReg;
    assign outExponent  = expReg;
    assign outMantissa  = sigReg[MANT_W-1:0];
    assign outZero      = zeroReg;
    assign outOverflow  = ovfReg;
    assign outUnderflow = ufReg;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer with hand-computed expected results.
module tb_fp_normalizer;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic        inSign;
    logic [7:0]  inExponent;
    logic [24:0] inSignificand;
    logic        outValid;
    logic        outReady;
    logic        outSign;
    logic [7:0]  outExponent;
    logic [22:0] outMantissa;
    logic        outZero;
    logic        outOverflow;
    logic        outUnderflow;

    int checks = 0;
    int errors = 0;

    fp_normalizer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inValid       (inValid),
        .inReady       (inReady),
        .inSign        (inSign),
        .inExponent    (inExponent),
        .inSignificand (inSignificand),
        .outValid      (outValid),
        .outReady      (outReady),
        .outSign       (outSign),
        .outExponent   (outExponent),
        .outMantissa   (outMantissa),
        .outZero       (outZero),
        .outOverflow   (outOverflow),
        .outUnderflow  (outUnderflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Present one operand right after a negedge; returns cycles from acceptance to outValid
    task automatic runOp(input logic s, input logic [7:0] e, input logic [24:0] sg, output int lat);
        int waits;
        inSign        = s;
        inExponent    = e;
        inSignificand = sg;
        inValid       = 1'b1;
        waits = 0;
        while (!inReady && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkResult(input string tag, input int lat, input int wantLat,
                               input logic s, input logic [7:0] e, input logic [22:0] m,
                               input logic [2:0] flags);
        checkVal({tag, "_lat"}, lat, wantLat);
        checkVal({tag, "_valid"}, {31'd0, outValid}, 32'd1);
        checkVal({tag, "_sign"}, {31'd0, outSign}, {31'd0, s});
        checkVal({tag, "_exp"}, {24'd0, outExponent}, {24'd0, e});
        checkVal({tag, "_mant"}, {9'd0, outMantissa}, {9'd0, m});
        checkVal({tag, "_flags"}, {29'd0, outZero, outOverflow, outUnderflow}, {29'd0, flags});
    endtask

    task automatic popResult();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    initial begin
        int lat;
        rst_n         = 1'b0;
        inValid       = 1'b0;
        inSign        = 1'b0;
        inExponent    = '0;
        inSignificand = '0;
        outReady      = 1'b0;

        repeat (2) @(negedge clk);
        checkVal("rst_inReady", {31'd0, inReady}, 32'd0);
        checkVal("rst_outValid", {31'd0, outValid}, 32'd0);
        checkVal("rst_outs", {outSign, outExponent, outMantissa}, 32'd0);
        checkVal("rst_flags", {29'd0, outZero, outOverflow, outUnderflow}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkVal("rel_inReady", {31'd0, inReady}, 32'd1);

        // carry-out: right shift with sticky
        runOp(1'b1, 8'd130, 25'h1800001, lat);
        checkResult("carry", lat, 1, 1'b1, 8'd131, 23'h400001, 3'b000);
        popResult();

        // 19 left shifts
        runOp(1'b0, 8'd127, 25'h0000010, lat);
        checkResult("left", lat, 20, 1'b0, 8'd108, 23'h000000, 3'b000);
        popResult();

        // subnormal reached during shifting
        runOp(1'b0, 8'd3, 25'h0000100, lat);
        checkResult("uflow", lat, 3, 1'b0, 8'd0, 23'h000400, 3'b001);
        popResult();

        // carry into saturated exponent
        runOp(1'b0, 8'd254, 25'h1000000, lat);
        checkResult("oflow", lat, 1, 1'b0, 8'd255, 23'h000000, 3'b010);
        popResult();

        // zero significand
        runOp(1'b1, 8'd100, 25'h0000000, lat);
        checkResult("zero", lat, 1, 1'b1, 8'd0, 23'h000000, 3'b100);
        popResult();

        // exponent 255 passes through untouched
        runOp(1'b0, 8'd255, 25'h0000005, lat);
        checkResult("inf", lat, 1, 1'b0, 8'd255, 23'h000005, 3'b000);
        popResult();

        // exponent too small to shift: direct subnormal
        runOp(1'b0, 8'd1, 25'h0000123, lat);
        checkResult("tiny", lat, 1, 1'b0, 8'd0, 23'h000123, 3'b001);
        popResult();

        // backpressure and back-to-back operand
        runOp(1'b0, 8'd127, 25'h0800000, lat);
        checkResult("hold0", lat, 1, 1'b0, 8'd127, 23'h000000, 3'b000);
        inSign        = 1'b0;
        inExponent    = 8'd130;
        inSignificand = 25'h1800001;
        inValid       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal("hold_valid", {31'd0, outValid}, 32'd1);
            checkVal("hold_inReady", {31'd0, inReady}, 32'd0);
            checkVal("hold_data", {1'b0, outExponent, outMantissa}, {1'b0, 8'd127, 23'h000000});
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkVal("b2b_outValid", {31'd0, outValid}, 32'd0);
        checkVal("b2b_inReady", {31'd0, inReady}, 32'd1);
        @(negedge clk);
        inValid = 1'b0;
        checkResult("b2b", 1, 1, 1'b0, 8'd131, 23'h400001, 3'b000);
        popResult();

        // reset during the third shift
        inSign        = 1'b1;
        inExponent    = 8'd127;
        inSignificand = 25'h0000010;
        inValid       = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("mid_busy", {31'd0, inReady}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkVal("mid_outValid", {31'd0, outValid}, 32'd0);
        checkVal("mid_outs", {outSign, outExponent, outMantissa}, 32'd0);
        checkVal("mid_inReady", {31'd0, inReady}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("mid_rel", {31'd0, inReady}, 32'd1);
        runOp(1'b0, 8'd127, 25'h0800000, lat);
        checkResult("after", lat, 1, 1'b0, 8'd127, 23'h000000, 3'b000);
        popResult();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
